// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit path and the future receive path.
//   - Default timing and data-width constants.
//   - Transmit FSM state encoding, as localparam constants.
//   - Even-parity helper.
// Optional feature macro: FIFO_UART_TX_PARITY_EN
//   - When defined, the PARITY state and the parity helper are added.
package uart_pkg;

    // 100 MHz system clock / 9600 baud, rounded.
    localparam int unsigned CLKS_PER_BIT_DEF = 10417;
    localparam int unsigned DATA_W_DEF       = 8;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t IDLE   = 3'd0;
    localparam tx_state_t START  = 3'd1;
    localparam tx_state_t DATA   = 3'd2;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam tx_state_t PARITY = 3'd3;
`endif
    localparam tx_state_t STOP   = 3'd4;

`ifdef FIFO_UART_TX_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W_DEF-1:0] data);
        return ^data;
    endfunction
`endif

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: per-bit clock counter for UART framing.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   restart  in   holds the counter at 0 on the next clock
//   count    out  current count, 0 .. CLKS_PER_BIT-1
//   bit_end  out  high on the last clock of a bit (count == CLKS_PER_BIT-1)
// The counter wraps to 0 after bit_end, so each bit starts at count 0 with no
// free-running offset carried between bits.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    output logic [CNT_W-1:0] count,
    output logic             bit_end
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_nxt;

    assign bit_end = (count == LAST_CNT);

    always_comb begin
        count_nxt = count + CNT_W'(1);
        if (restart || bit_end) begin
            count_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a show-ahead byte FIFO onto a UART tx line.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   fifo_empty  in   FIFO empty flag
//   fifo_rdata  in   FIFO head data, valid while fifo_empty = 0
//   fifo_pop    out  one-cycle pop strobe (combinational, only in IDLE)
//   tx          out  registered serial line, idle high
//   tx_busy     out  high from the pop edge to the end of the stop bit
//   tx_done     out  one-cycle pulse on the last clock of the stop bit
// Frame: start bit, DATA_W data bits LSB first, [parity bit,] stop bit.
// Optional feature macro: FIFO_UART_TX_PARITY_EN (adds an even parity bit).
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_pop,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // tx_done is registered, so it is set one clock before the stop bit's last clock.
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    tx_state_t         state, state_nxt;
    logic [DATA_W-1:0] shift_reg, shift_nxt;
    logic [BIT_W-1:0]  bit_idx, bit_idx_nxt;
    logic              tx_nxt;
    logic              busy_nxt;
    logic              done_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              parity_bit, parity_nxt;
`endif

    logic [CNT_W-1:0]  clk_cnt;
    logic              bit_end;

    // Held at 0 while idle so the start bit gets a full CLKS_PER_BIT clocks.
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (state == IDLE),
        .count   (clk_cnt),
        .bit_end (bit_end)
    );

    // Gated by rst so no pop can escape while the transmitter is held in reset.
    assign fifo_pop = rst && (state == IDLE) && !fifo_empty;

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_idx_nxt = bit_idx;
        tx_nxt      = tx;
        busy_nxt    = tx_busy;
        done_nxt    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_nxt  = parity_bit;
`endif

        case (state)
            IDLE: begin
                if (fifo_pop) begin
                    // Data is captured only here; later FIFO changes cannot alter this frame.
                    shift_nxt   = fifo_rdata;
                    bit_idx_nxt = '0;
                    tx_nxt      = 1'b0;
                    busy_nxt    = 1'b1;
                    state_nxt   = START;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_nxt  = even_parity(fifo_rdata);
`endif
                end
            end

            START: begin
                if (bit_end) begin
                    tx_nxt      = shift_reg[0];
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end
            end

            DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_nxt    = parity_bit;
                        state_nxt = PARITY;
`else
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
`endif
                    end else begin
                        // Next bit is shift_reg[1], which becomes bit 0 after the shift.
                        shift_nxt   = {1'b0, shift_reg[DATA_W-1:1]};
                        tx_nxt      = shift_reg[1];
                        bit_idx_nxt = bit_idx + BIT_W'(1);
                    end
                end
            end

`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_nxt    = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif

            STOP: begin
                if (clk_cnt == DONE_CNT) begin
                    done_nxt = 1'b1;
                end
                if (bit_end) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            shift_reg  <= shift_nxt;
            bit_idx    <= bit_idx_nxt;
            tx         <= tx_nxt;
            tx_busy    <= busy_nxt;
            tx_done    <= done_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_bit <= parity_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed self-checking bench for fifo_uart_tx with CLKS_PER_BIT = 4.
// A small show-ahead FIFO model feeds the DUT; tx/tx_busy/tx_done are logged
// per clock on the falling edge and frames are compared against hand-derived bits.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME   = NBITS * CPB;
    localparam int SPACING = FRAME + 1;
    localparam int LOG_N   = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_pop;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_pop   (fifo_pop),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    // Show-ahead FIFO model.
    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_rdata = mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (fifo_pop) rd_ptr <= rd_ptr + 1;
    end

    // cyc = number of rising edges seen; logs index by the edge that produced the value.
    int   cyc = 0;
    logic tx_log   [0:LOG_N-1];
    logic done_log [0:LOG_N-1];
    logic busy_log [0:LOG_N-1];
    int   pops [$];
    int   bad_pop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            tx_log[cyc]   <= tx;
            done_log[cyc] <= tx_done;
            busy_log[cyc] <= tx_busy;
        end
        if (fifo_pop) begin
            pops.push_back(cyc + 1);
            if (fifo_empty) bad_pop <= bad_pop + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[5:0]] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // e = rising edge on which the byte was popped.
    task automatic check_frame(input string tag, input int e, input logic [7:0] d);
        for (int b = 0; b < NBITS; b++) begin
            for (int k = 0; k < CPB; k++) begin
                check($sformatf("%s tx bit%0d clk%0d", tag, b, k),
                      32'(tx_log[e + b*CPB + k]), 32'(exp_bit(d, b)));
            end
        end
        check($sformatf("%s busy at pop", tag),     32'(busy_log[e]),             32'd1);
        check($sformatf("%s busy last clk", tag),   32'(busy_log[e + FRAME - 1]), 32'd1);
        check($sformatf("%s busy after", tag),      32'(busy_log[e + FRAME]),     32'd0);
        check($sformatf("%s done early", tag),      32'(done_log[e + FRAME - 2]), 32'd0);
        check($sformatf("%s done pulse", tag),      32'(done_log[e + FRAME - 1]), 32'd1);
        check($sformatf("%s done after", tag),      32'(done_log[e + FRAME]),     32'd0);
    endtask

    function automatic int pop_at(input int i);
        return (pops.size() > i) ? pops[i] : 0;
    endfunction

    initial begin
        int r;
        int e;
        int t0;
        int zeros;
        int n_before;

        // Reset with a non-empty FIFO: nothing may escape.
        rst = 1'b1;
        push(8'hA5);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset tx",   32'(tx),       32'd1);
            check("reset pop",  32'(fifo_pop), 32'd0);
            check("reset busy", 32'(tx_busy),  32'd0);
            check("reset done", 32'(tx_done),  32'd0);
        end

        // Single byte 0xA5.
        rst = 1'b1;
        r = cyc;
        repeat (FRAME + 10) @(negedge clk);
        check("single pop count", 32'(pops.size()), 32'd1);
        check("single pop edge",  32'(pop_at(0)),   32'(r + 1));
        if (pops.size() > 0) check_frame("single A5", pops[0], 8'hA5);

        // Back-to-back 0x00, 0xFF, 0x55.
        pops.delete();
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        r = cyc;
        repeat (3 * SPACING + 20) @(negedge clk);
        check("b2b pop count", 32'(pops.size()),             32'd3);
        check("b2b first pop", 32'(pop_at(0)),               32'(r + 1));
        check("b2b spacing1",  32'(pop_at(1) - pop_at(0)),   32'(SPACING));
        check("b2b spacing2",  32'(pop_at(2) - pop_at(1)),   32'(SPACING));
        if (pops.size() == 3) begin
            check_frame("b2b 00", pops[0], 8'h00);
            check_frame("b2b FF", pops[1], 8'hFF);
            check_frame("b2b 55", pops[2], 8'h55);
        end

        // Empty hold.
        pops.delete();
        t0 = cyc;
        repeat (200) @(negedge clk);
        zeros = 0;
        for (int i = t0 + 1; i < cyc; i++) if (tx_log[i] !== 1'b1) zeros++;
        check("empty no pop",  32'(pops.size()), 32'd0);
        check("empty tx high", 32'(zeros),       32'd0);

        // Reset during data bit 3 of 0x3C, then 0x81 after release.
        pops.delete();
        push(8'h3C);
        for (int i = 0; i < 10 && pops.size() == 0; i++) @(negedge clk);
        check("midreset pop seen", 32'(pops.size()), 32'd1);
        e = pop_at(0);
        // Data bit 3 occupies frame bit 4: edges e+16 .. e+19.
        for (int i = 0; i < 40 && cyc < e + 17; i++) @(negedge clk);
        check("midreset in bit3 busy", 32'(tx_busy), 32'd1);
        check("midreset in bit3 tx",   32'(tx),      32'(exp_bit(8'h3C, 4)));
        #2 rst = 1'b0;
        #1;
        check("midreset tx now",   32'(tx),      32'd1);
        check("midreset busy now", 32'(tx_busy), 32'd0);
        push(8'h81);
        repeat (3) @(negedge clk);
        check("midreset tx held", 32'(tx),       32'd1);
        check("midreset no pop",  32'(fifo_pop), 32'd0);
        n_before = pops.size();
        rst = 1'b1;
        r = cyc;
        repeat (SPACING + 10) @(negedge clk);
        check("midreset pops total", 32'(pops.size()), 32'(n_before + 1));
        check("midreset repop edge", 32'(pop_at(n_before)), 32'(r + 1));
        check("midreset idle tx",    32'(tx_log[r]), 32'd1);
        if (pops.size() == n_before + 1) check_frame("midreset 81", pops[n_before], 8'h81);

`ifdef FIFO_UART_TX_PARITY_EN
        // Parity: 0x07 has three ones, so the even parity bit is 1.
        pops.delete();
        push(8'h07);
        push(8'h07);
        r = cyc;
        repeat (2 * SPACING + 10) @(negedge clk);
        check("parity pop count", 32'(pops.size()),           32'd2);
        check("parity spacing",   32'(pop_at(1) - pop_at(0)), 32'd45);
        if (pops.size() == 2) begin
            check_frame("parity 07a", pops[0], 8'h07);
            check_frame("parity 07b", pops[1], 8'h07);
            check("parity bit", 32'(tx_log[pops[0] + 9*CPB]), 32'd1);
        end
`endif

        check("pop while empty", 32'(bad_pop), 32'd0);
        check("fifo drained",    32'(rd_ptr),  32'(wr_ptr));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
